// File: rtl/axis_unpack.sv
// AXI-Stream width down-converter: one wide word out as Ratio narrow beats.
// Optional packet-last passthrough enabled by AXIS_UNPACK_LAST_EN.
module axis_unpack #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Ratio     = 4,
  parameter bit          MsbFirst  = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [Ratio*DataWidth-1:0] s_data_i,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic                       m_ready_i,
  output logic                       m_valid_o,
  output logic [DataWidth-1:0]       m_data_o
`ifdef AXIS_UNPACK_LAST_EN
  ,
  input  logic                       s_last_i,
  output logic                       m_last_o
`endif
);

  localparam int unsigned IdxW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  typedef enum logic {Empty, Busy} state_e;

  state_e                     state_q;
  logic [IdxW-1:0]            idx_q;
  logic [IdxW-1:0]            idx_d;
  logic [IdxW-1:0]            sel;
  logic [Ratio*DataWidth-1:0] word_q;
  logic                       last_beat;
  logic                       s_fire;
  logic                       m_fire;

  assign last_beat = (idx_q == LastIdx);
  assign m_valid_o = (state_q == Busy);
  assign s_ready_o = (state_q == Empty) | (last_beat & m_ready_i);
  assign s_fire    = s_valid_i & s_ready_o;
  assign m_fire    = m_valid_o & m_ready_i;
  assign idx_d     = idx_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= Empty;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        Empty: begin
          if (s_fire) begin
            state_q <= Busy;
            idx_q   <= '0;
          end
        end
        Busy: begin
          if (m_fire) begin
            if (last_beat) begin
              idx_q   <= '0;
              state_q <= s_fire ? Busy : Empty;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        default: begin
          state_q <= Empty;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Payload needs no reset: it is only observed while m_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (s_fire) word_q <= s_data_i;
  end

  assign sel      = MsbFirst ? (LastIdx - idx_q) : idx_q;
  assign m_data_o = word_q[sel*DataWidth +: DataWidth];

`ifdef AXIS_UNPACK_LAST_EN
  logic last_q;

  always_ff @(posedge clk_i) begin
    if (s_fire) last_q <= s_last_i;
  end

  assign m_last_o = last_q & last_beat & m_valid_o;
`endif

endmodule

// File: tb/tb_axis_unpack.sv
// Directed bench for axis_unpack: LSB/MSB order, back-to-back words,
// random backpressure, mid-word reset, Ratio=3 and optional last flag.
module tb_axis_unpack;

  logic clk;
  logic rst_n;

  logic [63:0] d0;
  logic        v0, sr0, mr0, mv0;
  logic [15:0] md0;
  logic [63:0] d1;
  logic        v1, sr1, mr1, mv1;
  logic [15:0] md1;
  logic [23:0] d2;
  logic        v2, sr2, mr2, mv2;
  logic [7:0]  md2;
`ifdef AXIS_UNPACK_LAST_EN
  logic sl0, ml0, sl1, ml1, sl2, ml2;
`endif

  int passed = 0;
  int total  = 0;

  axis_unpack u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_data_i(d0), .s_valid_i(v0), .s_ready_o(sr0),
    .m_ready_i(mr0), .m_valid_o(mv0), .m_data_o(md0)
`ifdef AXIS_UNPACK_LAST_EN
    , .s_last_i(sl0), .m_last_o(ml0)
`endif
  );

  axis_unpack #(.MsbFirst(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_data_i(d1), .s_valid_i(v1), .s_ready_o(sr1),
    .m_ready_i(mr1), .m_valid_o(mv1), .m_data_o(md1)
`ifdef AXIS_UNPACK_LAST_EN
    , .s_last_i(sl1), .m_last_o(ml1)
`endif
  );

  axis_unpack #(.DataWidth(8), .Ratio(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_data_i(d2), .s_valid_i(v2), .s_ready_o(sr2),
    .m_ready_i(mr2), .m_valid_o(mv2), .m_data_o(md2)
`ifdef AXIS_UNPACK_LAST_EN
    , .s_last_i(sl2), .m_last_o(ml2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [15:0] exp3 [4];
    int k;
    int cyc;

    rst_n = 1'b0;
    d0 = '0; v0 = 1'b0; mr0 = 1'b1;
    d1 = '0; v1 = 1'b0; mr1 = 1'b1;
    d2 = '0; v2 = 1'b0; mr2 = 1'b1;
`ifdef AXIS_UNPACK_LAST_EN
    sl0 = 1'b0; sl1 = 1'b0; sl2 = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 64'(mv0), 64'd0);
    chk("rst_ready", 64'(sr0), 64'd1);
`ifdef AXIS_UNPACK_LAST_EN
    chk("rst_last", 64'(ml0), 64'd0);
`endif

    // single word, LSB first
    d0 = 64'h4444_3333_2222_1111;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("t1_b0", 64'(md0), 64'h1111);
    chk("t1_v0", 64'(mv0), 64'd1);
    chk("t1_r0", 64'(sr0), 64'd0);
    step();
    chk("t1_b1", 64'(md0), 64'h2222);
    chk("t1_r1", 64'(sr0), 64'd0);
    step();
    chk("t1_b2", 64'(md0), 64'h3333);
    chk("t1_r2", 64'(sr0), 64'd0);
    step();
    chk("t1_b3", 64'(md0), 64'h4444);
    chk("t1_r3", 64'(sr0), 64'd1);
    step();
    chk("t1_idle", 64'(mv0), 64'd0);

    // back-to-back words, no bubble
    d0 = 64'h0004_0003_0002_0001;
    v0 = 1'b1;
    step();
    d0 = 64'h0008_0007_0006_0005;
`ifdef AXIS_UNPACK_LAST_EN
    sl0 = 1'b1;
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_v%0d", i), 64'(mv0), 64'd1);
      chk($sformatf("t2_d%0d", i), 64'(md0), 64'(i + 1));
`ifdef AXIS_UNPACK_LAST_EN
      chk($sformatf("t2_l%0d", i), 64'(ml0), 64'(i == 7));
`endif
      step();
      if (i == 3) v0 = 1'b0;
    end
`ifdef AXIS_UNPACK_LAST_EN
    sl0 = 1'b0;
`endif
    chk("t2_idle", 64'(mv0), 64'd0);

    // random backpressure
    exp3[0] = 16'hAAAA; exp3[1] = 16'hBBBB;
    exp3[2] = 16'hCCCC; exp3[3] = 16'hDDDD;
    d0 = 64'hDDDD_CCCC_BBBB_AAAA;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 200) begin
      mr0 = 1'($urandom_range(0, 1));
      #1;
      chk("t3_valid", 64'(mv0), 64'd1);
      chk("t3_data", 64'(md0), 64'(exp3[k]));
      chk("t3_ready", 64'(sr0), 64'(k == 3 && mr0));
      step();
      if (mr0) k++;
      cyc++;
    end
    chk("t3_done", 64'(k), 64'd4);
    mr0 = 1'b1;
    #1;
    chk("t3_idle", 64'(mv0), 64'd0);

    // reset mid-word
    d0 = 64'h4444_3333_2222_1111;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("t5_b0", 64'(md0), 64'h1111);
    step();
    chk("t5_b1", 64'(md0), 64'h2222);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_valid", 64'(mv0), 64'd0);
    chk("t5_ready", 64'(sr0), 64'd1);
    d0 = 64'h8888_7777_6666_5555;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("t5_n0", 64'(md0), 64'h5555);
    step();
    chk("t5_n1", 64'(md0), 64'h6666);
    step();
    step();
    chk("t5_n3", 64'(md0), 64'h8888);
    step();
    chk("t5_idle", 64'(mv0), 64'd0);

    // MSB-first ordering
    d1 = 64'hAAAA_BBBB_CCCC_DDDD;
    v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("t4_b0", 64'(md1), 64'hAAAA);
    step();
    chk("t4_b1", 64'(md1), 64'hBBBB);
    step();
    chk("t4_b2", 64'(md1), 64'hCCCC);
    step();
    chk("t4_b3", 64'(md1), 64'hDDDD);
    step();
    chk("t4_idle", 64'(mv1), 64'd0);

    // Ratio=3: idx runs 0,1,2,0,1,2
    d2 = 24'h33_22_11;
    v2 = 1'b1;
    step();
    d2 = 24'h66_55_44;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_v%0d", i), 64'(mv2), 64'd1);
      chk($sformatf("t6_d%0d", i), 64'(md2), 64'(8'h11 * (i + 1)));
      chk($sformatf("t6_r%0d", i), 64'(sr2), 64'(i == 2 || i == 5));
      step();
      if (i == 2) v2 = 1'b0;
    end
    chk("t6_idle", 64'(mv2), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
